y86_execute_stage: RTL and testbench

- Execute stage of the pipelined Y86-64 core.
- Selects ALU operands and function from the decoded E-register fields, drives the existing 64-bit ALU, and consumes its result and overflow.
- Holds the condition-code register and evaluates jXX/cmovXX conditions.
- Registers results into the E/M pipeline register that feeds the memory stage.

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/y86_cond_eval.sv | 33 +++
 rtl/y86_execute_stage.sv | 139 +++++++++++++
 tb/tb_y86_execute_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the E/M pipeline bundle.
// Imported by the execute stage and its condition evaluator.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSHQ = 4'hA;
    localparam logic [3:0] I_POPQ  = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam logic [63:0] K_NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] K_POS8 = 64'd8;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } em_t;

endpackage

// File: rtl/y86_cond_eval.sv
// Y86 jXX/cmovXX condition evaluator, purely combinational.
// Ports: cc {ZF,SF,OF}, ifun condition code -> cnd.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    always_comb begin
        cnd = 1'b0;
        unique case (ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = (sf ^ of) | zf;
            C_L:      cnd = sf ^ of;
            C_E:      cnd = zf;
            C_NE:     cnd = !zf;
            C_GE:     cnd = !(sf ^ of);
            C_G:      cnd = !(sf ^ of) & !zf;
            default:  cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU operand select, CC register, E/M register.
// Ports: E_* decoded fields in, alu_* to/from external ALU, e_* fwd, M_* out.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = REG_NONE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic         m_stat_exc,
    input  logic         W_stat_exc,
    input  logic         M_bubble,
    output logic [1:0]   alu_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_ans,
    input  logic         alu_of,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [2:0]   cc,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam em_t EM_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    logic [W-1:0] alu_a_sel;
    logic [W-1:0] alu_b_sel;
    logic [2:0]   cc_q;
    logic         set_cc;
    em_t          em_d;
    em_t          em_q;

    always_comb begin
        alu_a_sel = '0;
        unique case (1'b1)
            (E_icode == I_RRMOV) || (E_icode == I_OPQ):
                alu_a_sel = E_valA;
            (E_icode == I_IRMOV) || (E_icode == I_RMMOV) ||
            (E_icode == I_MRMOV):
                alu_a_sel = E_valC;
            (E_icode == I_CALL) || (E_icode == I_PUSHQ):
                alu_a_sel = K_NEG8;
            (E_icode == I_RET) || (E_icode == I_POPQ):
                alu_a_sel = K_POS8;
            default:
                alu_a_sel = '0;
        endcase
    end

    always_comb begin
        alu_b_sel = '0;
        unique case (1'b1)
            (E_icode == I_RMMOV) || (E_icode == I_MRMOV) ||
            (E_icode == I_OPQ)   || (E_icode == I_CALL)  ||
            (E_icode == I_RET)   || (E_icode == I_PUSHQ) ||
            (E_icode == I_POPQ):
                alu_b_sel = E_valB;
            default:
                alu_b_sel = '0;
        endcase
    end

    // Swapped so that the ALU's a - b computes valB - valA.
    assign alu_a    = alu_b_sel;
    assign alu_b    = alu_a_sel;
    assign alu_ctrl = (E_icode == I_OPQ) ? E_ifun[1:0] : ALU_ADD;

    // Conditions see the flags from before this instruction's update.
    cond_eval u_cond (
        .cc   (cc_q),
        .ifun (E_ifun),
        .cnd  (e_Cnd)
    );

    assign e_valE = alu_ans;
    assign e_dstE = ((E_icode == I_RRMOV) && !e_Cnd) ? RNONE : E_dstE;

    // Younger exceptional instructions must not disturb architectural flags.
    assign set_cc = (E_icode == I_OPQ) && (E_stat == S_AOK) &&
                    !m_stat_exc && !W_stat_exc;

    always_comb begin
        em_d = '{
            stat:  E_stat,
            icode: E_icode,
            cnd:   e_Cnd,
            val_e: alu_ans,
            val_a: E_valA,
            dst_e: e_dstE,
            dst_m: E_dstM
        };
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
            em_q <= EM_BUBBLE;
        end else begin
            if (set_cc) begin
                cc_q <= {alu_ans == '0, alu_ans[W-1], alu_of};
            end
            em_q <= M_bubble ? EM_BUBBLE : em_d;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = em_q.stat;
    assign M_icode = em_q.icode;
    assign M_Cnd   = em_q.cnd;
    assign M_valE  = em_q.val_e;
    assign M_valA  = em_q.val_a;
    assign M_dstE  = em_q.dst_e;
    assign M_dstM  = em_q.dst_m;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Bench for y86_execute_stage: directed plan plus random ops vs a model.
// Includes a behavioural stand-in for the external 64-bit ALU.
module tb_y86_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic        m_stat_exc;
    logic        W_stat_exc;
    logic        M_bubble;
    logic [1:0]  alu_ctrl;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_ans;
    logic        alu_of;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  cc;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    y86_execute_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .E_stat     (E_stat),
        .E_icode    (E_icode),
        .E_ifun     (E_ifun),
        .E_valC     (E_valC),
        .E_valA     (E_valA),
        .E_valB     (E_valB),
        .E_dstE     (E_dstE),
        .E_dstM     (E_dstM),
        .m_stat_exc (m_stat_exc),
        .W_stat_exc (W_stat_exc),
        .M_bubble   (M_bubble),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ans    (alu_ans),
        .alu_of     (alu_of),
        .e_valE     (e_valE),
        .e_dstE     (e_dstE),
        .e_Cnd      (e_Cnd),
        .cc         (cc),
        .M_stat     (M_stat),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valE     (M_valE),
        .M_valA     (M_valA),
        .M_dstE     (M_dstE),
        .M_dstM     (M_dstM)
    );

    // External ALU: 00 a+b, 01 a-b, 10 a&b, 11 a^b; OF on add/sub only.
    logic [64:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        alu_ans  = '0;
        alu_of   = 1'b0;
        case (alu_ctrl)
            2'b00: begin
                alu_wide = {alu_a[63], alu_a} + {alu_b[63], alu_b};
                alu_ans  = alu_wide[63:0];
                alu_of   = alu_wide[64] ^ alu_wide[63];
            end
            2'b01: begin
                alu_wide = {alu_a[63], alu_a} - {alu_b[63], alu_b};
                alu_ans  = alu_wide[63:0];
                alu_of   = alu_wide[64] ^ alu_wide[63];
            end
            2'b10: alu_ans = alu_a & alu_b;
            default: alu_ans = alu_a ^ alu_b;
        endcase
    end

    // Reference model state.
    logic [2:0]  m_cc;
    logic [2:0]  x_stat;
    logic [3:0]  x_icode;
    logic        x_cnd;
    logic [63:0] x_valE;
    logic [63:0] x_valA;
    logic [3:0]  x_dstE;
    logic [3:0]  x_dstM;

    function automatic logic [63:0] ref_valE(
        input logic [3:0] ic, input logic [3:0] fn,
        input logic [63:0] c, input logic [63:0] a, input logic [63:0] b);
        case (ic)
            4'h2:       return a;
            4'h3:       return c;
            4'h4, 4'h5: return b + c;
            4'h6: begin
                case (fn[1:0])
                    2'd0:    return b + a;
                    2'd1:    return b - a;
                    2'd2:    return b & a;
                    default: return b ^ a;
                endcase
            end
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic ref_of(
        input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = a;
        sb = b;
        if (fn[1:0] == 2'd0) begin
            r = sb + sa;
            return (sa < 0) == (sb < 0) && (r < 0) != (sb < 0);
        end
        if (fn[1:0] == 2'd1) begin
            r = sb - sa;
            return (sa < 0) != (sb < 0) && (r < 0) != (sb < 0);
        end
        return 1'b0;
    endfunction

    function automatic logic ref_cnd(input logic [3:0] fn, input logic [2:0] f);
        logic zf;
        logic lt;
        zf = f[2];
        lt = f[1] ^ f[0];
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return lt | zf;
            4'd2:    return lt;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [63:0] c,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic mx, input logic wx, input logic bub,
                         input logic rn);
        E_stat = st;
        E_icode = ic;
        E_ifun = fn;
        E_valC = c;
        E_valA = a;
        E_valB = b;
        E_dstE = de;
        E_dstM = dm;
        m_stat_exc = mx;
        W_stat_exc = wx;
        M_bubble = bub;
        rst_n = rn;
    endtask

    task automatic set_bubble();
        x_stat = 3'd1;
        x_icode = 4'h1;
        x_cnd = 1'b0;
        x_valE = '0;
        x_valA = '0;
        x_dstE = 4'hF;
        x_dstM = 4'hF;
    endtask

    // Inputs already driven; check forwarding, clock, check E/M and cc.
    task automatic step(input string tag);
        logic [63:0] ev;
        logic        ec;
        logic [3:0]  ed;
        logic        sc;
        #2;
        ev = ref_valE(E_icode, E_ifun, E_valC, E_valA, E_valB);
        ec = ref_cnd(E_ifun, m_cc);
        ed = (E_icode == 4'h2 && !ec) ? 4'hF : E_dstE;
        sc = E_icode == 4'h6 && E_stat == 3'd1 && !m_stat_exc && !W_stat_exc;
        chk({tag, ".e_valE"}, e_valE, ev);
        chk({tag, ".e_Cnd"}, {63'd0, e_Cnd}, {63'd0, ec});
        chk({tag, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, ed});
        @(posedge clk);
        if (!rst_n) begin
            m_cc = 3'b100;
            set_bubble();
        end else begin
            if (sc) m_cc = {ev == 64'd0, ev[63], ref_of(E_ifun, E_valA, E_valB)};
            if (M_bubble) begin
                set_bubble();
            end else begin
                x_stat = E_stat;
                x_icode = E_icode;
                x_cnd = ec;
                x_valE = ev;
                x_valA = E_valA;
                x_dstE = ed;
                x_dstM = E_dstM;
            end
        end
        #1;
        chk({tag, ".cc"}, {61'd0, cc}, {61'd0, m_cc});
        chk({tag, ".M_stat"}, {61'd0, M_stat}, {61'd0, x_stat});
        chk({tag, ".M_icode"}, {60'd0, M_icode}, {60'd0, x_icode});
        chk({tag, ".M_Cnd"}, {63'd0, M_Cnd}, {63'd0, x_cnd});
        chk({tag, ".M_valE"}, M_valE, x_valE);
        chk({tag, ".M_valA"}, M_valA, x_valA);
        chk({tag, ".M_dstE"}, {60'd0, M_dstE}, {60'd0, x_dstE});
        chk({tag, ".M_dstM"}, {60'd0, M_dstM}, {60'd0, x_dstM});
    endtask

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [3:0]  ric;
        logic [3:0]  rfn;
        logic [2:0]  rst_v;

        drive(3'd1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_cc = 3'b100;
        set_bubble();
        chk("rst.cc", {61'd0, cc}, 64'h4);
        chk("rst.M_icode", {60'd0, M_icode}, 64'h1);
        chk("rst.M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rst.M_stat", {61'd0, M_stat}, 64'h1);
        rst_n = 1'b1;

        drive(3'd1, 4'h6, 4'h1, 0, 64'd3, 64'd5, 4'h2, 4'hF, 0, 0, 0, 1);
        step("subq_3_5");
        chk("subq_3_5.cc_const", {61'd0, cc}, 64'h0);
        chk("subq_3_5.valE_const", M_valE, 64'd2);

        drive(3'd1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 0, 0, 0, 1);
        step("subq_5_5");
        chk("subq_5_5.cc_const", {61'd0, cc}, 64'h4);

        drive(3'd1, 4'h6, 4'h0, 0, MAXP, MAXP, 4'h1, 4'hF, 0, 0, 0, 1);
        step("addq_ovf");
        chk("addq_ovf.valE_const", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("addq_ovf.cc_const", {61'd0, cc}, 64'h3);

        drive(3'd1, 4'h7, 4'h2, 64'h40, 0, 0, 4'hF, 4'hF, 0, 0, 0, 1);
        step("jl_ovf");
        chk("jl_ovf.M_Cnd_const", {63'd0, M_Cnd}, 64'd0);

        drive(3'd1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 0, 0, 0, 1);
        step("subq_zero");
        drive(3'd1, 4'h2, 4'h1, 0, 64'h55, 64'h0, 4'h3, 4'hF, 0, 0, 0, 1);
        step("cmovle_taken");
        chk("cmovle_taken.M_dstE_const", {60'd0, M_dstE}, 64'h3);

        drive(3'd1, 4'h6, 4'h1, 0, 64'd3, 64'd5, 4'h2, 4'hF, 0, 0, 0, 1);
        step("subq_pos");
        drive(3'd1, 4'h2, 4'h1, 0, 64'h55, 64'h0, 4'h3, 4'hF, 0, 0, 0, 1);
        step("cmovle_not");
        chk("cmovle_not.M_dstE_const", {60'd0, M_dstE}, 64'hF);

        drive(3'd1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 1, 0, 0, 1);
        step("opq_mexc");
        chk("opq_mexc.cc_const", {61'd0, cc}, 64'h0);
        drive(3'd4, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 0, 0, 0, 1);
        step("opq_ins");
        chk("opq_ins.cc_const", {61'd0, cc}, 64'h0);
        drive(3'd1, 4'h6, 4'h1, 0, 64'd5, 64'd5, 4'h2, 4'hF, 0, 1, 0, 1);
        step("opq_wexc");

        drive(3'd1, 4'hA, 4'h0, 0, 64'h9, 64'h100, 4'h4, 4'hF, 0, 0, 0, 1);
        step("pushq");
        chk("pushq.valE_const", M_valE, 64'hF8);
        drive(3'd1, 4'hA, 4'h0, 0, 64'h9, 64'h100, 4'h4, 4'hF, 0, 0, 1, 1);
        step("pushq_bub");
        chk("pushq_bub.icode_const", {60'd0, M_icode}, 64'h1);
        drive(3'd1, 4'h6, 4'h0, 0, MAXP, MAXP, 4'h1, 4'hF, 0, 0, 1, 0);
        step("rst_opq");
        chk("rst_opq.cc_const", {61'd0, cc}, 64'h4);

        drive(3'd1, 4'hA, 4'h0, 0, 64'h0, 64'h0, 4'h4, 4'hF, 0, 0, 0, 1);
        step("pushq_wrap");
        chk("pushq_wrap.valE_const", M_valE, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("pushq_wrap.cc_const", {61'd0, cc}, 64'h4);

        drive(3'd1, 4'h6, 4'h0, 0, MAXP, MAXP, 4'h1, 4'hF, 0, 0, 0, 1);
        step("addq_ovf2");
        drive(3'd1, 4'h6, 4'h2, 0, '1, '1, 4'h1, 4'hF, 0, 0, 0, 1);
        step("andq_clr_of");
        chk("andq_clr_of.cc_const", {61'd0, cc}, 64'h2);

        for (int i = 0; i < 400; i++) begin
            ric = 4'($urandom_range(0, 15));
            rfn = (ric == 4'h6) ? 4'($urandom_range(0, 3))
                                : 4'($urandom_range(0, 8));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: begin
                    ra = 64'($urandom_range(0, 16));
                    rb = 64'($urandom_range(0, 16));
                end
                2: rb = ra ^ 64'h8000_0000_0000_0000;
                default: ;
            endcase
            rst_v = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4))
                                                : 3'd1;
            drive(rst_v, ric, rfn, {$urandom, $urandom}, ra, rb,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 39) != 0);
            step($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
